// File: rtl/instr_fetch_buffer_pkg.sv
// Shared widths, FSM encoding and FIFO entry type for the instruction fetch buffer.
package instr_fetch_buffer_pkg;

  localparam int ADDR_W     = 10;
  localparam int WORD_W     = 10;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef logic [ADDR_W-1:0] pc_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    pc_t   pc;
    word_t word;
  } entry_t;

  // Value presented on instr whenever nothing is queued.
  localparam word_t OP_NOP = '0;

  // PC arithmetic wraps naturally at 2**ADDR_W.
  function automatic pc_t pc_step(input pc_t pc, input logic two);
    return pc + (two ? pc_t'(2) : pc_t'(1));
  endfunction

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Decoder-side valid/ready handshake carrying one instruction word and its PC.
interface instr_fetch_buffer_if;
  import instr_fetch_buffer_pkg::*;

  logic  instr_valid;
  logic  instr_ready;
  word_t instr;
  pc_t   instr_pc;

  modport master (output instr_valid, output instr, output instr_pc, input  instr_ready);
  modport slave  (input  instr_valid, input  instr, input  instr_pc, output instr_ready);
endinterface

// File: rtl/instr_fetch_buffer_fifo.sv
// Small {pc, word} FIFO accepting 0/1/2 pushes and 0/1 pop per cycle, with flush.
module instr_fetch_buffer_fifo
  import instr_fetch_buffer_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       push_n,
  input  entry_t           push0,
  input  entry_t           push1,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_p1;
  logic             do_pop;

  assign do_pop    = pop && (count != '0);
  assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
  assign head      = mem[rd_ptr];

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(do_pop);
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      count  <= count + CNT_W'(push_n) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem[wr_ptr]    <= push0;
    if (push_n == 2'd2) mem[wr_ptr_p1] <= push1;
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: drives the paired-word RAM address, unpacks pairs into the FIFO,
// and presents words to the decoder. Holds the IDLE/RUN/DRAIN control FSM.
module instr_fetch_buffer
  import instr_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  pc_t                     start_pc,
  input  logic                    redirect,
  input  pc_t                     redirect_pc,
  input  logic                    halt,
  input  logic                    stall_fetch,
  output pc_t                     mem_address,
  input  logic [2*WORD_W-1:0]     mem_rdata,
  output logic                    busy,
  instr_fetch_buffer_if.master    dec
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  pc_t              fetch_pc_q, fetch_pc_d;
  logic [1:0]       push_n;
  logic             flush;
  logic             pop;
  entry_t           push0, push1, head;
  logic [CNT_W-1:0] count, free;
  word_t            rdata_lo, rdata_hi;

  assign rdata_lo = mem_rdata[WORD_W-1:0];
  assign rdata_hi = mem_rdata[2*WORD_W-1:WORD_W];

  // An odd fetch PC only wants the high half of its pair.
  assign push0 = '{pc: fetch_pc_q, word: fetch_pc_q[0] ? rdata_hi : rdata_lo};
  assign push1 = '{pc: pc_step(fetch_pc_q, 1'b0), word: rdata_hi};

  // Free slots come from the pre-pop count, so a pop never makes room for this cycle's capture.
  assign free = CNT_W'(DEPTH) - count;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push_n     = 2'd0;
    flush      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          fetch_pc_d = start_pc;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end else if (halt) begin
          state_d = ST_DRAIN;
        end else if (!stall_fetch) begin
          if (!fetch_pc_q[0] && free >= CNT_W'(2)) begin
            push_n     = 2'd2;
            fetch_pc_d = pc_step(fetch_pc_q, 1'b1);
          end else if (fetch_pc_q[0] && free >= CNT_W'(1)) begin
            push_n     = 2'd1;
            fetch_pc_d = pc_step(fetch_pc_q, 1'b0);
          end
        end
      end
      ST_DRAIN: begin
        // Redirect revives fetching and overrides a concurrent halt.
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          state_d    = ST_RUN;
        end else if (count == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign pop = dec.instr_valid && dec.instr_ready && !flush;

  instr_fetch_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .push_n (push_n),
    .push0  (push0),
    .push1  (push1),
    .pop    (pop),
    .head   (head),
    .count  (count)
  );

  assign dec.instr_valid = (count != '0);
  assign dec.instr       = dec.instr_valid ? head.word : OP_NOP;
  assign dec.instr_pc    = dec.instr_valid ? head.pc   : '0;
  assign mem_address     = fetch_pc_q;
  assign busy            = (state_q != ST_IDLE);

endmodule
